// File: rtl/i2c_eeprom_pkg.sv
// Shared types and constants for the I2C EEPROM target.
// Holds the protocol state encoding, ACK/NACK levels and the default 7-bit address.
package i2c_eeprom_pkg;

  localparam logic       ACK_BIT             = 1'b0;
  localparam logic       NACK_BIT            = 1'b1;
  localparam logic [6:0] DEFAULT_DEVICE_ADDR = 7'h50;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_AHI,
    ST_AHI_ACK,
    ST_ALO,
    ST_ALO_ACK,
    ST_WDAT,
    ST_WDAT_ACK,
    ST_RDAT,
    ST_RACK,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/i2c_eeprom_if.sv
// Pad-side I2C lines plus the fabric read port and write notification of the EEPROM target.
interface i2c_eeprom_if #(
  parameter int IDX_W = 7
);
  logic             scl_in;
  logic             sda_in;
  logic             sda_oe;
  logic [IDX_W-1:0] host_addr;
  logic [7:0]       host_rdata;
  logic             wr_strobe;
  logic [IDX_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             busy;

  modport slave (
    input  scl_in, sda_in, host_addr,
    output sda_oe, host_rdata, wr_strobe, wr_addr, wr_data, busy
  );

  modport master (
    output scl_in, sda_in, host_addr,
    input  sda_oe, host_rdata, wr_strobe, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises and glitch-filters SCL/SDA, then derives registered edge and
// START/STOP pulses; reusable by any I2C block running on clk.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_f,
  output logic start,
  output logic stop
);

  logic [1:0] pad;
  logic [1:0] filt_vec;
  logic [1:0] next_vec;

  assign pad = {sda_in, scl_in};

  // Line 0 is SCL, line 1 is SDA; both idle high on an I2C bus.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic s1_reg, s2_reg, s3_reg, filt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_reg   <= 1'b1;
          s2_reg   <= 1'b1;
          s3_reg   <= 1'b1;
          filt_reg <= 1'b1;
        end else begin
          s1_reg <= pad[gi];
          s2_reg <= s1_reg;
          s3_reg <= s2_reg;
          if (s2_reg == s3_reg)
            filt_reg <= s2_reg;
        end
      end

      assign filt_vec[gi] = filt_reg;
      assign next_vec[gi] = (s2_reg == s3_reg) ? s2_reg : filt_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      scl_rise <= ~filt_vec[0] &  next_vec[0];
      scl_fall <=  filt_vec[0] & ~next_vec[0];
      start    <=  filt_vec[0] &  next_vec[0] &  filt_vec[1] & ~next_vec[1];
      stop     <=  filt_vec[0] &  next_vec[0] & ~filt_vec[1] &  next_vec[1];
    end
  end

  assign sda_f = filt_vec[1];

endmodule

// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a 24LC-style EEPROM with 16-bit word addressing over an
// on-chip byte array, with a registered fabric read port and per-byte write notification.
module i2c_eeprom_target
  import i2c_eeprom_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = DEFAULT_DEVICE_ADDR,
  parameter int         MEM_SIZE    = 'h80,
  parameter int         IDX_W       = $clog2(MEM_SIZE)
) (
  input  logic         clk,
  input  logic         rst,
  i2c_eeprom_if.slave  bus
);

  logic scl_rise, scl_fall, sda_f, start, stop;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (bus.scl_in),
    .sda_in   (bus.sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_f    (sda_f),
    .start    (start),
    .stop     (stop)
  );

  state_t           state_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       addr_hi_reg;
  logic [15:0]      ptr_reg;
  logic             rw_reg;
  logic             load_pending_reg;
  logic             sda_oe_reg;
  logic             busy_reg;
  logic             wr_strobe_reg;
  logic [IDX_W-1:0] wr_addr_reg;
  logic [7:0]       wr_data_reg;
  logic [7:0]       host_rdata_reg;
  logic [7:0]       rd_byte_reg;

  logic [7:0] mem [MEM_SIZE] = '{default: 8'hFF};

  logic [7:0]       byte_in;
  logic             byte_done;
  logic [IDX_W-1:0] ptr_idx;

  assign byte_in   = {shift_reg[6:0], sda_f};
  assign byte_done = (bit_cnt_reg == 3'd7);
  assign ptr_idx   = ptr_reg[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      bit_cnt_reg      <= '0;
      shift_reg        <= '0;
      addr_hi_reg      <= '0;
      ptr_reg          <= '0;
      rw_reg           <= 1'b0;
      load_pending_reg <= 1'b0;
      sda_oe_reg       <= 1'b0;
      busy_reg         <= 1'b0;
      wr_strobe_reg    <= 1'b0;
      wr_addr_reg      <= '0;
      wr_data_reg      <= '0;
    end else begin
      wr_strobe_reg <= 1'b0;
      if (start) begin
        state_reg        <= ST_DEV;
        bit_cnt_reg      <= '0;
        sda_oe_reg       <= 1'b0;
        load_pending_reg <= 1'b0;
      end else if (stop) begin
        state_reg  <= ST_IDLE;
        sda_oe_reg <= 1'b0;
        busy_reg   <= 1'b0;
      end else if (scl_rise) begin
        case (state_reg)
          ST_DEV, ST_AHI, ST_ALO, ST_WDAT: begin
            shift_reg   <= byte_in;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (byte_done) begin
              case (state_reg)
                ST_DEV: begin
                  if (byte_in[7:1] == DEVICE_ADDR) begin
                    state_reg <= ST_DEV_ACK;
                    rw_reg    <= byte_in[0];
                    busy_reg  <= 1'b1;
                  end else begin
                    state_reg <= ST_WAIT;
                    busy_reg  <= 1'b0;
                  end
                end
                ST_AHI: begin
                  addr_hi_reg <= byte_in;
                  state_reg   <= ST_AHI_ACK;
                end
                ST_ALO: begin
                  ptr_reg   <= {addr_hi_reg, byte_in};
                  state_reg <= ST_ALO_ACK;
                end
                default: begin
                  wr_strobe_reg <= 1'b1;
                  wr_addr_reg   <= ptr_idx;
                  wr_data_reg   <= byte_in;
                  ptr_reg       <= ptr_reg + 16'd1;
                  state_reg     <= ST_WDAT_ACK;
                end
              endcase
            end
          end
          ST_RDAT: begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (byte_done)
              state_reg <= ST_RACK;
          end
          ST_RACK: begin
            // The pointer advances past every byte sent, acknowledged or not.
            ptr_reg <= ptr_reg + 16'd1;
            if (sda_f == ACK_BIT) begin
              state_reg        <= ST_RDAT;
              bit_cnt_reg      <= '0;
              load_pending_reg <= 1'b1;
            end else begin
              state_reg <= ST_WAIT;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_reg)
          // First fall in an ACK state pulls SDA low; the second ends the ACK bit.
          ST_DEV_ACK, ST_AHI_ACK, ST_ALO_ACK, ST_WDAT_ACK: begin
            if (!sda_oe_reg) begin
              sda_oe_reg <= 1'b1;
            end else begin
              sda_oe_reg <= 1'b0;
              case (state_reg)
                ST_DEV_ACK: begin
                  if (rw_reg) begin
                    state_reg   <= ST_RDAT;
                    bit_cnt_reg <= '0;
                    sda_oe_reg  <= ~rd_byte_reg[7];
                    shift_reg   <= {rd_byte_reg[6:0], 1'b1};
                  end else begin
                    state_reg <= ST_AHI;
                  end
                end
                ST_AHI_ACK: state_reg <= ST_ALO;
                default:    state_reg <= ST_WDAT;
              endcase
            end
          end
          ST_RDAT: begin
            if (load_pending_reg) begin
              load_pending_reg <= 1'b0;
              sda_oe_reg       <= ~rd_byte_reg[7];
              shift_reg        <= {rd_byte_reg[6:0], 1'b1};
            end else begin
              sda_oe_reg <= ~shift_reg[7];
              shift_reg  <= {shift_reg[6:0], 1'b1};
            end
          end
          ST_RACK: sda_oe_reg <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // The array is deliberately outside reset so configuration survives rst.
  always_ff @(posedge clk) begin
    if (wr_strobe_reg)
      mem[wr_addr_reg] <= wr_data_reg;
    rd_byte_reg <= mem[ptr_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      host_rdata_reg <= '0;
    else
      host_rdata_reg <= mem[bus.host_addr];
  end

  assign bus.sda_oe     = sda_oe_reg;
  assign bus.busy       = busy_reg;
  assign bus.wr_strobe  = wr_strobe_reg;
  assign bus.wr_addr    = wr_addr_reg;
  assign bus.wr_data    = wr_data_reg;
  assign bus.host_rdata = host_rdata_reg;

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Directed bench for i2c_eeprom_target: bit-banged I2C initiator on an
// open-drain SDA model, write-strobe logger and host-port reads.
module tb_i2c_eeprom_target;

  localparam int IDX_W = 7;
  localparam int Q     = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_drv = 1'b1;
  logic m_low = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [IDX_W-1:0] st_addr [$];
  logic [7:0]       st_data [$];

  i2c_eeprom_if #(.IDX_W(IDX_W)) bus ();

  assign bus.scl_in = scl_drv;
  assign bus.sda_in = ~(m_low | bus.sda_oe);

  i2c_eeprom_target #(
    .DEVICE_ADDR (7'h50),
    .MEM_SIZE    ('h80)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_strobe) begin
      st_addr.push_back(bus.wr_addr);
      st_data.push_back(bus.wr_data);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic i2c_start();
    m_low = 1'b0;  #Q;
    scl_drv = 1'b1; #Q;
    m_low = 1'b1;  #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;  #Q;
    scl_drv = 1'b1; #Q;
    m_low = 1'b0;  #Q;
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b;    #Q;
    scl_drv = 1'b1; #Q;
    #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0;  #Q;
    scl_drv = 1'b1; #Q;
    b = bus.sda_in;
    #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    acked = (b == 1'b0);
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~send_ack);
  endtask

  task automatic host_read(input logic [IDX_W-1:0] a, output logic [7:0] d);
    @(negedge clk) bus.host_addr = a;
    @(negedge clk) d = bus.host_rdata;
  endtask

  // Sends START plus a byte list and checks each byte is acknowledged.
  task automatic send_acked(input string name, input logic [7:0] bytes [], input logic with_start);
    logic ok;
    if (with_start) i2c_start();
    foreach (bytes[i]) begin
      write_byte(bytes[i], ok);
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL %s_ack%0d: got ack=%b required ack=1 (byte %h)", name, i, ok, bytes[i]);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    bus.host_addr = '0;
    repeat (4) @(negedge clk);
    checks += 6;
    if (bus.sda_oe !== 1'b0)    begin errors++; $display("FAIL reset_sda_oe: got %b required 0", bus.sda_oe); end
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    if (bus.wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_wr_strobe: got %b required 0", bus.wr_strobe); end
    if (bus.wr_addr !== '0)     begin errors++; $display("FAIL reset_wr_addr: got %h required 00", bus.wr_addr); end
    if (bus.wr_data !== 8'h00)  begin errors++; $display("FAIL reset_wr_data: got %h required 00", bus.wr_data); end
    if (bus.host_rdata !== 8'h00) begin errors++; $display("FAIL reset_host_rdata: got %h required 00", bus.host_rdata); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    host_read(7'h05, d);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL init_array: got %h required ff", d); end
    $display("reset: outputs cleared, array[05]=%h", d);
  endtask

  task automatic test_random_write();
    logic [7:0] d;
    int n0 = st_addr.size();
    send_acked("rw", '{8'hA0}, 1'b1);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL rw_busy_mid: got %b required 1", bus.busy); end
    send_acked("rw", '{8'h00, 8'h05, 8'h3C}, 1'b0);
    i2c_stop();
    repeat (8) @(negedge clk);
    checks += 2;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rw_busy_end: got %b required 0", bus.busy); end
    if (st_addr.size() != n0 + 1) begin
      errors++; $display("FAIL rw_strobes: got %0d required 1", st_addr.size() - n0);
    end else begin
      checks += 2;
      if (st_addr[n0] !== 7'h05) begin errors++; $display("FAIL rw_wr_addr: got %h required 05", st_addr[n0]); end
      if (st_data[n0] !== 8'h3C) begin errors++; $display("FAIL rw_wr_data: got %h required 3c", st_data[n0]); end
    end
    host_read(7'h05, d);
    checks++;
    if (d !== 8'h3C) begin errors++; $display("FAIL rw_host_rdata: got %h required 3c", d); end
    $display("random write: addr 0005 data 3c, host_rdata=%h", d);
  endtask

  task automatic test_random_read();
    logic [7:0] d;
    send_acked("rr", '{8'hA0, 8'h00, 8'h05}, 1'b1);
    send_acked("rr", '{8'hA1}, 1'b1);
    read_byte(1'b0, d);
    checks += 2;
    if (d !== 8'h3C) begin errors++; $display("FAIL rr_data: got %h required 3c", d); end
    if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL rr_release_after_nack: got %b required 0", bus.sda_oe); end
    i2c_stop();
    $display("random read: addr 0005 data %h", d);
    // Current-address read must continue from 0006.
    send_acked("cur", '{8'hA1}, 1'b1);
    read_byte(1'b0, d);
    i2c_stop();
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL cur_read_ptr6: got %h required ff", d); end
    $display("current-address read: data %h", d);
  endtask

  task automatic test_page_write();
    logic [IDX_W-1:0] exp_a [3] = '{7'h7E, 7'h7F, 7'h00};
    logic [7:0]       exp_d [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] d;
    int n0 = st_addr.size();
    send_acked("pw", '{8'hA0, 8'h00, 8'h7E, 8'h11, 8'h22, 8'h33}, 1'b1);
    i2c_stop();
    repeat (8) @(negedge clk);
    checks++;
    if (st_addr.size() != n0 + 3) begin
      errors++; $display("FAIL pw_strobes: got %0d required 3", st_addr.size() - n0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (st_addr[n0+i] !== exp_a[i]) begin errors++; $display("FAIL pw_wr_addr%0d: got %h required %h", i, st_addr[n0+i], exp_a[i]); end
        if (st_data[n0+i] !== exp_d[i]) begin errors++; $display("FAIL pw_wr_data%0d: got %h required %h", i, st_data[n0+i], exp_d[i]); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      host_read(exp_a[i], d);
      checks++;
      if (d !== exp_d[i]) begin errors++; $display("FAIL pw_host%0d: got %h required %h", i, d, exp_d[i]); end
      $display("page write: index %h data %h", exp_a[i], d);
    end
  endtask

  task automatic test_seq_read();
    logic [7:0] exp_d [4] = '{8'h22, 8'h33, 8'hFF, 8'hFF};
    logic [7:0] d;
    send_acked("sr", '{8'hA0, 8'h00, 8'h7F}, 1'b1);
    send_acked("sr", '{8'hA1}, 1'b1);
    for (int i = 0; i < 4; i++) begin
      read_byte(i != 3, d);
      checks++;
      if (d !== exp_d[i]) begin errors++; $display("FAIL sr_byte%0d: got %h required %h", i, d, exp_d[i]); end
      $display("sequential read: byte %0d data %h", i, d);
    end
    i2c_stop();
  endtask

  task automatic test_wrong_addr();
    logic ok;
    int n0 = st_addr.size();
    i2c_start();
    write_byte(8'hA4, ok);
    checks += 2;
    if (ok !== 1'b0) begin errors++; $display("FAIL wa_dev_nack: got ack=%b required ack=0", ok); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL wa_busy: got %b required 0", bus.busy); end
    write_byte(8'h00, ok);
    checks++;
    if (ok !== 1'b0) begin errors++; $display("FAIL wa_byte_nack: got ack=%b required ack=0", ok); end
    i2c_stop();
    repeat (8) @(negedge clk);
    checks++;
    if (st_addr.size() != n0) begin errors++; $display("FAIL wa_strobes: got %0d required 0", st_addr.size() - n0); end
    $display("wrong address a4: ack=%b", ok);
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] d;
    logic [7:0] v = 8'h5A;
    int n0;
    send_acked("rm", '{8'hA0, 8'h00, 8'h10}, 1'b1);
    n0 = st_addr.size();
    for (int i = 7; i >= 4; i--) write_bit(v[i]);
    rst = 1'b1;
    #1;
    checks += 2;
    if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL rm_sda_oe: got %b required 0", bus.sda_oe); end
    if (bus.busy !== 1'b0)   begin errors++; $display("FAIL rm_busy: got %b required 0", bus.busy); end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    for (int i = 3; i >= 0; i--) write_bit(v[i]);
    i2c_stop();
    repeat (8) @(negedge clk);
    host_read(7'h10, d);
    checks += 2;
    if (st_addr.size() != n0) begin errors++; $display("FAIL rm_strobes: got %0d required 0", st_addr.size() - n0); end
    if (d !== 8'hFF) begin errors++; $display("FAIL rm_array: got %h required ff", d); end
    $display("reset mid-write: array[10]=%h", d);
  endtask

  initial begin
    test_reset();
    test_random_write();
    test_random_read();
    test_page_write();
    test_seq_read();
    test_wrong_addr();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
